move_request_arbiter: RTL and testbench

//  Front-end controller for game2048. Collects move requests from two requesters (debounced

---
 rtl/move_request_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_move_request_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_request_arbiter.sv
// move_request_arbiter: front-end for game2048. Debounces the push buttons,
// accepts external valid/ready requests, arbitrates round-robin between the
// two single-entry request slots and drives one direction pulse per move,
// then follows the core's ready handshake until the move has completed.
module move_request_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ACCEPT_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_dir,
  input  logic        ext_valid,
  input  logic [3:0]  ext_dir,
  output logic        ext_ready,
  input  logic [1:0]  game_state,
  input  logic        core_ready,
  output logic [3:0]  dir_out,
  output logic        grant_src,
  output logic [15:0] move_count,
  output logic        err_timeout,
  output logic        invalid_cmd
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACCEPT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE
  } state_e;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Button synchroniser and debouncer state
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      last_q, last_d;
  logic [3:0]      deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  // Request slots, arbitration and handshake state
  state_e          state_q, state_d;
  logic            btn_full_q, btn_full_d;
  logic [3:0]      btn_slot_q, btn_slot_d;
  logic            ext_full_q, ext_full_d;
  logic [3:0]      ext_slot_q, ext_slot_d;
  logic [3:0]      lat_q, lat_d;
  logic            src_q, src_d;
  logic            rr_q, rr_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [15:0]     count_q, count_d;
  logic            err_q, err_d;
  logic            inv_q, inv_d;
  logic            ext_ready_q, ext_ready_d;

  logic game_over;
  logic xfer;
  logic pick_ext;
  logic grant_btn;

  assign game_over = game_state[1];
  assign xfer      = ext_valid && ext_ready_q && !game_over;

  // Synchronise buttons; restart the shared counter on any change and accept
  // the vector once it has been stable long enough. A press is a stable
  // vector that adds a bit and is exactly one-hot.
  always_comb begin
    sync1_d  = btn_dir;
    sync2_d  = sync1_q;
    last_d   = sync2_q;
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    press    = 1'b0;
    if (sync2_q != last_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      deb_d = last_q;
      press = (last_q != deb_q) && is_onehot(last_q) &&
              ((last_q & ~deb_q) != 4'd0);
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Next-state for the move FSM, request slots, counters and pulses
  always_comb begin
    state_d    = state_q;
    btn_full_d = btn_full_q;
    btn_slot_d = btn_slot_q;
    ext_full_d = ext_full_q;
    ext_slot_d = ext_slot_q;
    lat_d      = lat_q;
    src_d      = src_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    count_d    = count_q;
    err_d      = 1'b0;
    inv_d      = 1'b0;
    grant_btn  = 1'b0;
    pick_ext   = ext_full_q && (!btn_full_q || rr_q);

    if (game_over) begin
      state_d    = S_IDLE;
      btn_full_d = 1'b0;
      ext_full_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (core_ready && (btn_full_q || ext_full_q)) begin
            src_d = pick_ext;
            rr_d  = !pick_ext;
            if (pick_ext) begin
              lat_d      = ext_slot_q;
              ext_full_d = 1'b0;
            end else begin
              lat_d      = btn_slot_q;
              btn_full_d = 1'b0;
              grant_btn  = 1'b1;
            end
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT_ACCEPT;
        end
        S_WAIT_ACCEPT: begin
          if (!core_ready) begin
            state_d = S_WAIT_DONE;
          end else if (timer_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (core_ready) begin
            count_d = count_q + 16'd1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A slot granted this cycle may refill at the same edge: the grant
      // already took the old content, so the new request simply waits.
      if (press && (!btn_full_q || grant_btn)) begin
        btn_full_d = 1'b1;
        btn_slot_d = last_q;
      end
      if (xfer) begin
        if (is_onehot(ext_dir)) begin
          ext_full_d = 1'b1;
          ext_slot_d = ext_dir;
        end else begin
          inv_d = 1'b1;
        end
      end
    end

    ext_ready_d = !ext_full_d && !game_over;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      last_q      <= '0;
      deb_q       <= '0;
      db_cnt_q    <= '0;
      state_q     <= S_IDLE;
      btn_full_q  <= 1'b0;
      btn_slot_q  <= '0;
      ext_full_q  <= 1'b0;
      ext_slot_q  <= '0;
      lat_q       <= '0;
      src_q       <= 1'b0;
      rr_q        <= 1'b0;
      timer_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      inv_q       <= 1'b0;
      ext_ready_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      last_q      <= last_d;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      btn_full_q  <= btn_full_d;
      btn_slot_q  <= btn_slot_d;
      ext_full_q  <= ext_full_d;
      ext_slot_q  <= ext_slot_d;
      lat_q       <= lat_d;
      src_q       <= src_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      err_q       <= err_d;
      inv_q       <= inv_d;
      ext_ready_q <= ext_ready_d;
    end
  end

  // Direction is only driven during the single issue cycle and never in lockout
  assign dir_out     = (state_q == S_ISSUE && !game_over) ? lat_q : '0;
  assign grant_src   = src_q;
  assign move_count  = count_q;
  assign err_timeout = err_q;
  assign invalid_cmd = inv_q;
  assign ext_ready   = ext_ready_q;

endmodule

// File: tb/tb_move_request_arbiter.sv
// Self-checking bench for move_request_arbiter: directed sequences, a vector
// table of external commands and a randomized run against a reference model.
module tb_move_request_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn_dir = '0;
  logic        ext_valid = 1'b0;
  logic [3:0]  ext_dir = '0;
  logic        ext_ready;
  logic [1:0]  game_state = 2'b01;
  logic        core_ready = 1'b1;
  logic [3:0]  dir_out;
  logic        grant_src;
  logic [15:0] move_count;
  logic        err_timeout;
  logic        invalid_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt = '0;

  move_request_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .ACCEPT_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_dir(btn_dir),
    .ext_valid(ext_valid),
    .ext_dir(ext_dir),
    .ext_ready(ext_ready),
    .game_state(game_state),
    .core_ready(core_ready),
    .dir_out(dir_out),
    .grant_src(grant_src),
    .move_count(move_count),
    .err_timeout(err_timeout),
    .invalid_cmd(invalid_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dir;
    logic       exp_inv;
    logic       exp_ready;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    btn_dir = '0;
    ext_valid = 1'b0;
    game_state = 2'b01;
    repeat (2) tick();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ext_ready && k < 30) begin
      tick();
      k++;
    end
    check("ext_ready_wait", ext_ready, 1);
  endtask

  task automatic ext_send(input logic [3:0] d);
    wait_ready();
    ext_valid = 1'b1;
    ext_dir = d;
    tick();
    ext_valid = 1'b0;
  endtask

  task automatic wait_pulse(output logic [3:0] d, output logic s);
    int k = 0;
    do begin
      tick();
      k++;
    end while (dir_out == 4'd0 && k < 60);
    check("pulse_seen", 32'(dir_out != 4'd0), 1);
    d = dir_out;
    s = grant_src;
  endtask

  // Called in the issue cycle: accept (ready low) then complete (ready high)
  task automatic finish_move();
    core_ready = 1'b0;
    tick();
    tick();
    core_ready = 1'b1;
    tick();
    exp_cnt++;
  endtask

  task automatic press_btn(input logic [3:0] d);
    btn_dir = d;
    repeat (12) tick();
    btn_dir = '0;
    repeat (10) tick();
  endtask

  task automatic do_move(input logic [3:0] d);
    logic [3:0] got;
    logic s;
    ext_send(d);
    wait_pulse(got, s);
    check("move_dir", got, d);
    finish_move();
  endtask

  // Reference model for the external path (buttons held idle)
  int         m_stage;   // 0 idle, 1 issuing, 2 awaiting accept, 3 awaiting done
  int         m_wait;
  bit         m_ready, m_full, m_src, m_inv, m_err;
  logic [3:0] m_sdir, m_lat;
  logic [15:0] m_cnt;

  function automatic bit onehot4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += v[i];
    return n == 1;
  endfunction

  task automatic model_step(input logic v, input logic [3:0] d, input logic cr, input logic [1:0] gs);
    bit go = gs[1];
    bit take = v && m_ready && !go;
    bit granted = 0;
    m_inv = take && !onehot4(d);
    m_err = 0;
    if (go) begin
      m_stage = 0;
      m_full = 0;
    end else begin
      if (m_stage == 0) begin
        if (cr && m_full) begin
          granted = 1;
          m_lat = m_sdir;
          m_src = 1;
          m_stage = 1;
        end
      end else if (m_stage == 1) begin
        m_stage = 2;
        m_wait = 0;
      end else if (m_stage == 2) begin
        if (!cr) m_stage = 3;
        else begin
          m_wait++;
          if (m_wait == TO) begin
            m_err = 1;
            m_stage = 0;
          end
        end
      end else begin
        if (cr) begin
          m_cnt++;
          m_stage = 0;
        end
      end
      if (granted) m_full = 0;
      if (take && onehot4(d)) begin
        m_full = 1;
        m_sdir = d;
      end
    end
    m_ready = !m_full && !go;
  endtask

  initial begin
    logic [3:0] got;
    logic       s;
    int         pulses;
    int         k;
    logic [3:0] one;

    vecs[0] = '{dir: 4'b0001, exp_inv: 1'b0, exp_ready: 1'b0, exp_out: 4'b0001};
    vecs[1] = '{dir: 4'b0110, exp_inv: 1'b1, exp_ready: 1'b1, exp_out: 4'b0000};
    vecs[2] = '{dir: 4'b0010, exp_inv: 1'b0, exp_ready: 1'b0, exp_out: 4'b0010};
    vecs[3] = '{dir: 4'b0000, exp_inv: 1'b1, exp_ready: 1'b1, exp_out: 4'b0000};
    vecs[4] = '{dir: 4'b0100, exp_inv: 1'b0, exp_ready: 1'b0, exp_out: 4'b0100};
    vecs[5] = '{dir: 4'b1111, exp_inv: 1'b1, exp_ready: 1'b1, exp_out: 4'b0000};
    vecs[6] = '{dir: 4'b1000, exp_inv: 1'b0, exp_ready: 1'b0, exp_out: 4'b1000};
    vecs[7] = '{dir: 4'b1001, exp_inv: 1'b1, exp_ready: 1'b1, exp_out: 4'b0000};

    // Reset state
    #3;
    check("rst_dir", dir_out, 0);
    check("rst_ready", ext_ready, 0);
    check("rst_count", move_count, 0);
    check("rst_src", grant_src, 0);
    check("rst_err", err_timeout, 0);
    check("rst_inv", invalid_cmd, 0);
    apply_reset();
    check("ready_after_release_pre", ext_ready, 0);
    tick();
    check("ready_after_release", ext_ready, 1);

    // Debounced button press gives one pulse and one completed move
    pulses = 0; got = '0; s = 1'b1; k = -10;
    btn_dir = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 9) btn_dir = '0;
      if (dir_out != 4'd0) begin
        pulses++;
        got = dir_out;
        s = grant_src;
        core_ready = 1'b0;
        k = i;
      end
      if (i == k + 2) core_ready = 1'b1;
    end
    check("btn_pulses", pulses, 1);
    check("btn_dir", got, 4'b0100);
    check("btn_src", s, 0);
    check("btn_count", move_count, 1);

    // Bouncing button never produces a move
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 24) btn_dir = (i % 4 < 2) ? 4'b0100 : 4'b0000;
      else btn_dir = '0;
      tick();
      if (dir_out != 4'd0) pulses++;
    end
    check("bounce_pulses", pulses, 0);

    // Round-robin: both pending after reset -> buttons first
    apply_reset();
    core_ready = 1'b0;
    press_btn(4'b1000);
    ext_send(4'b0001);
    core_ready = 1'b1;
    wait_pulse(got, s);
    check("rr1_dir", got, 4'b1000);
    check("rr1_src", s, 0);
    finish_move();
    wait_pulse(got, s);
    check("rr2_dir", got, 4'b0001);
    check("rr2_src", s, 1);
    finish_move();
    check("rr_count", move_count, exp_cnt);

    // Contest again (ext last) -> buttons; refill buttons mid-move -> ext next
    core_ready = 1'b0;
    press_btn(4'b0100);
    ext_send(4'b0010);
    core_ready = 1'b1;
    wait_pulse(got, s);
    check("rr3_dir", got, 4'b0100);
    check("rr3_src", s, 0);
    core_ready = 1'b0;
    tick();
    tick();
    press_btn(4'b1000);
    core_ready = 1'b1;
    exp_cnt++;
    wait_pulse(got, s);
    check("rr4_dir", got, 4'b0010);
    check("rr4_src", s, 1);
    finish_move();
    wait_pulse(got, s);
    check("rr5_dir", got, 4'b1000);
    check("rr5_src", s, 0);
    finish_move();
    check("rr_count2", move_count, exp_cnt);

    // Table of external commands
    for (int i = 0; i < 8; i++) begin
      ext_send(vecs[i].dir);
      check("tbl_inv", invalid_cmd, vecs[i].exp_inv);
      check("tbl_ready", ext_ready, vecs[i].exp_ready);
      tick();
      check("tbl_dir", dir_out, vecs[i].exp_out);
      check("tbl_inv_clear", invalid_cmd, 0);
      if (vecs[i].exp_out != 4'd0) begin
        check("tbl_src", grant_src, 1);
        finish_move();
        check("tbl_count", move_count, exp_cnt);
      end else begin
        tick();
        check("tbl_no_dir", dir_out, 0);
        check("tbl_ready_back", ext_ready, 1);
      end
    end

    // Accept timeout: ready held high through the whole accept window
    ext_send(4'b0100);
    tick();
    check("to_issue", dir_out, 4'b0100);
    for (int j = 0; j < TO; j++) begin
      tick();
      check("to_err_early", err_timeout, 0);
    end
    tick();
    check("to_err_pulse", err_timeout, 1);
    check("to_count", move_count, exp_cnt);
    tick();
    check("to_err_clear", err_timeout, 0);
    check("to_no_dir", dir_out, 0);

    // Game-over lockout with both slots full
    core_ready = 1'b0;
    press_btn(4'b0010);
    ext_send(4'b1000);
    game_state = 2'b11;
    core_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dir_out != 4'd0) pulses++;
    end
    check("go_ready", ext_ready, 0);
    check("go_pulses", pulses, 0);
    game_state = 2'b01;
    tick();
    check("go_ready_back", ext_ready, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dir_out != 4'd0) pulses++;
    end
    check("go_slots_cleared", pulses, 0);
    check("go_count_kept", move_count, exp_cnt);

    // Reset in WAIT_DONE
    apply_reset();
    core_ready = 1'b1;
    for (int i = 0; i < 5; i++) do_move(vecs[2 * (i % 4)].dir);
    check("pre_rst_count", move_count, 5);
    ext_send(4'b0001);
    wait_pulse(got, s);
    core_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_dir", dir_out, 0);
    check("mid_rst_count", move_count, 0);
    check("mid_rst_src", grant_src, 0);
    check("mid_rst_ready", ext_ready, 0);
    check("mid_rst_err", err_timeout, 0);
    check("mid_rst_inv", invalid_cmd, 0);
    tick();
    rst = 1'b1;
    core_ready = 1'b1;
    tick();
    check("post_rst_ready", ext_ready, 1);
    check("post_rst_dir", dir_out, 0);

    // Counter wrap
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    check("wrap_pre", move_count, 16'hFFFF);
    do_move(4'b1000);
    check("wrap_post", move_count, 0);

    // Randomized external traffic against the model
    apply_reset();
    core_ready = 1'b1;
    m_stage = 0; m_wait = 0; m_ready = 0; m_full = 0; m_src = 0;
    m_inv = 0; m_err = 0; m_sdir = '0; m_lat = '0; m_cnt = '0;
    one = 4'b0001;
    for (int c = 0; c < 1500; c++) begin
      ext_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) ext_dir = one << $urandom_range(0, 3);
      else ext_dir = 4'($urandom);
      if ($urandom_range(0, 3) == 0) core_ready = ~core_ready;
      if (!game_state[1] && $urandom_range(0, 79) == 0)
        game_state = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
      else if (game_state[1] && $urandom_range(0, 3) == 0)
        game_state = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
      model_step(ext_valid, ext_dir, core_ready, game_state);
      tick();
      check("rnd_dir", dir_out, (m_stage == 1 && !game_state[1]) ? m_lat : 4'd0);
      check("rnd_ready", ext_ready, m_ready);
      check("rnd_inv", invalid_cmd, m_inv);
      check("rnd_err", err_timeout, m_err);
      check("rnd_count", move_count, m_cnt);
      check("rnd_src", grant_src, m_src);
    end
    ext_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
